// File: rtl/mem_bus_bridge.sv
// Bridges the MEM-stage RAM port onto a two-phase (address/data) bus.
// Holds the pipeline while an access is in flight; parks in HOLD if the stage is already stalled.
`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 32
`endif

module mem_bus_bridge (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ram_en,
    input  logic                        ram_write_en,
    input  logic [3:0]                  ram_write_sel,
    input  logic [`DATA_BUS_WIDTH-1:0]  ram_addr,
    input  logic [`DATA_BUS_WIDTH-1:0]  ram_write_data,
    input  logic                        stall_current_stage,
    output logic [`DATA_BUS_WIDTH-1:0]  ram_read_data,
    output logic                        stall_request,
    output logic                        bus_req,
    output logic                        bus_we,
    output logic [3:0]                  bus_sel,
    output logic [`DATA_BUS_WIDTH-1:0]  bus_addr,
    output logic [`DATA_BUS_WIDTH-1:0]  bus_wdata,
    input  logic                        bus_addr_ok,
    input  logic                        bus_data_ok,
    input  logic [`DATA_BUS_WIDTH-1:0]  bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic [`DATA_BUS_WIDTH-1:0]   reqAddr_q, reqAddr_d;
    logic [`DATA_BUS_WIDTH-1:0]   reqWdata_q, reqWdata_d;
    logic [3:0]                   reqSel_q, reqSel_d;
    logic                         reqWe_q, reqWe_d;
    logic [`DATA_BUS_WIDTH-1:0]   readData_q, readData_d;

    logic zeroSelStore;
    logic startAccess;

    // A store with no byte enabled has nothing to do on the bus.
    assign zeroSelStore = ram_write_en && (ram_write_sel == 4'b0000);
    assign startAccess  = ram_en && !zeroSelStore;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            reqAddr_q  <= '0;
            reqWdata_q <= '0;
            reqSel_q   <= '0;
            reqWe_q    <= 1'b0;
            readData_q <= '0;
        end else begin
            state_q    <= state_d;
            reqAddr_q  <= reqAddr_d;
            reqWdata_q <= reqWdata_d;
            reqSel_q   <= reqSel_d;
            reqWe_q    <= reqWe_d;
            readData_q <= readData_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        reqAddr_d  = reqAddr_q;
        reqWdata_d = reqWdata_q;
        reqSel_d   = reqSel_q;
        reqWe_d    = reqWe_q;
        readData_d = readData_q;

        unique case (state_q)
            IDLE: begin
                if (startAccess) begin
                    state_d    = REQ;
                    reqAddr_d  = ram_addr;
                    reqWdata_d = ram_write_data;
                    reqWe_d    = ram_write_en;
                    reqSel_d   = ram_write_en ? ram_write_sel : 4'b1111;
                end
            end
            REQ: begin
                if (bus_addr_ok) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus_data_ok) begin
                    readData_d = bus_rdata;
                    state_d    = stall_current_stage ? HOLD : IDLE;
                end
            end
            HOLD: begin
                if (!stall_current_stage) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus fields are only presented while a transaction is outstanding.
    always_comb begin
        bus_req       = 1'b0;
        bus_we        = 1'b0;
        bus_sel       = 4'b0000;
        bus_addr      = '0;
        bus_wdata     = '0;
        stall_request = 1'b0;
        ram_read_data = readData_q;

        unique case (state_q)
            IDLE: begin
                stall_request = startAccess;
            end
            REQ: begin
                bus_req       = 1'b1;
                bus_we        = reqWe_q;
                bus_sel       = reqSel_q;
                bus_addr      = reqAddr_q;
                bus_wdata     = reqWdata_q;
                stall_request = 1'b1;
            end
            WAIT: begin
                bus_we        = reqWe_q;
                bus_sel       = reqSel_q;
                bus_addr      = reqAddr_q;
                bus_wdata     = reqWdata_q;
                stall_request = !bus_data_ok;
                if (bus_data_ok) begin
                    ram_read_data = bus_rdata;
                end
            end
            HOLD: begin
                stall_request = 1'b0;
            end
            default: begin
                stall_request = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Randomized transaction-level bench for mem_bus_bridge; expectations come from a
// per-access model of stall/bus timing and the read register contents.
module tb_mem_bus_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_en;
    logic        ram_write_en;
    logic [3:0]  ram_write_sel;
    logic [31:0] ram_addr;
    logic [31:0] ram_write_data;
    logic        stall_current_stage;
    logic [31:0] ram_read_data;
    logic        stall_request;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    int          checkCount = 0;
    int          errorCount = 0;
    logic [31:0] readModel = 32'h0;

    mem_bus_bridge dut (
        .clk                 (clk),
        .rst                 (rst),
        .ram_en              (ram_en),
        .ram_write_en        (ram_write_en),
        .ram_write_sel       (ram_write_sel),
        .ram_addr            (ram_addr),
        .ram_write_data      (ram_write_data),
        .stall_current_stage (stall_current_stage),
        .ram_read_data       (ram_read_data),
        .stall_request       (stall_request),
        .bus_req             (bus_req),
        .bus_we              (bus_we),
        .bus_sel             (bus_sel),
        .bus_addr            (bus_addr),
        .bus_wdata           (bus_wdata),
        .bus_addr_ok         (bus_addr_ok),
        .bus_data_ok         (bus_data_ok),
        .bus_rdata           (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // The stalled pipeline may present anything on the RAM side; the bridge must not care.
    task automatic scrambleRam();
        ram_addr       = $urandom;
        ram_write_data = $urandom;
        ram_write_sel  = 4'($urandom);
        ram_write_en   = 1'($urandom);
    endtask

    task automatic checkIdle(input string tag);
        @(negedge clk);
        checkOutput({tag, "_stall"}, 32'(stall_request), 32'd0);
        checkOutput({tag, "_req"},   32'(bus_req),       32'd0);
        checkOutput({tag, "_we"},    32'(bus_we),        32'd0);
        checkOutput({tag, "_sel"},   32'(bus_sel),       32'd0);
        checkOutput({tag, "_read"},  ram_read_data,      readModel);
    endtask

    task automatic applyStimulus(input bit isStore, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] sel, input int addrDelay, input int dataDelay,
                                 input bit holdAtEnd, input int holdExtra, input logic [31:0] rdata);
        logic [3:0] expSel;
        bit         zeroStore;
        bit         last;
        expSel    = isStore ? sel : 4'b1111;
        zeroStore = isStore && (sel == 4'b0000);

        ram_en              = 1'b1;
        ram_write_en        = isStore;
        ram_write_sel       = sel;
        ram_addr            = addr;
        ram_write_data      = wdata;
        stall_current_stage = 1'b1;
        bus_addr_ok         = 1'b0;
        bus_data_ok         = 1'($urandom);
        bus_rdata           = $urandom;
        @(negedge clk);
        checkOutput("detect_stall", 32'(stall_request), 32'(!zeroStore));
        checkOutput("detect_req",   32'(bus_req),       32'd0);
        checkOutput("detect_read",  ram_read_data,      readModel);
        nextCycle();

        if (!zeroStore) begin
            for (int i = 0; i <= addrDelay; i++) begin
                scrambleRam();
                bus_addr_ok = (i == addrDelay);
                bus_data_ok = 1'($urandom);
                bus_rdata   = $urandom;
                @(negedge clk);
                checkOutput("req_req",   32'(bus_req),       32'd1);
                checkOutput("req_we",    32'(bus_we),        32'(isStore));
                checkOutput("req_sel",   32'(bus_sel),       32'(expSel));
                checkOutput("req_addr",  bus_addr,           addr);
                checkOutput("req_wdata", bus_wdata,          wdata);
                checkOutput("req_stall", 32'(stall_request), 32'd1);
                checkOutput("req_read",  ram_read_data,      readModel);
                nextCycle();
            end
            bus_addr_ok = 1'b0;

            for (int j = 0; j <= dataDelay; j++) begin
                last = (j == dataDelay);
                scrambleRam();
                bus_data_ok         = last;
                bus_rdata           = last ? rdata : $urandom;
                stall_current_stage = last ? holdAtEnd : 1'b1;
                @(negedge clk);
                checkOutput("wait_req",   32'(bus_req),       32'd0);
                checkOutput("wait_sel",   32'(bus_sel),       32'(expSel));
                checkOutput("wait_addr",  bus_addr,           addr);
                checkOutput("wait_stall", 32'(stall_request), 32'(!last));
                checkOutput("wait_read",  ram_read_data,      last ? rdata : readModel);
                nextCycle();
            end
            readModel   = rdata;
            bus_data_ok = 1'b0;

            if (holdAtEnd) begin
                for (int k = 0; k <= holdExtra; k++) begin
                    scrambleRam();
                    ram_en              = (k != holdExtra);
                    stall_current_stage = (k != holdExtra);
                    bus_data_ok         = 1'($urandom);
                    bus_rdata           = $urandom;
                    @(negedge clk);
                    checkOutput("hold_stall", 32'(stall_request), 32'd0);
                    checkOutput("hold_req",   32'(bus_req),       32'd0);
                    checkOutput("hold_read",  ram_read_data,      readModel);
                    nextCycle();
                end
            end
        end

        ram_en              = 1'b0;
        stall_current_stage = 1'b0;
        bus_data_ok         = 1'($urandom);
        bus_rdata           = $urandom;
        checkIdle("after");
        nextCycle();
        bus_data_ok = 1'b0;
    endtask

    // Reset lands while a load is in REQ or WAIT; the late response must be dropped.
    task automatic resetDuringAccess(input bit inWait);
        ram_en              = 1'b1;
        ram_write_en        = 1'b0;
        ram_write_sel       = 4'b0000;
        ram_addr            = 32'h0000_0300;
        ram_write_data      = $urandom;
        stall_current_stage = 1'b1;
        bus_addr_ok         = 1'b0;
        bus_data_ok         = 1'b0;
        nextCycle();
        if (inWait) begin
            bus_addr_ok = 1'b1;
            nextCycle();
            bus_addr_ok = 1'b0;
        end
        rst = 1'b1;
        nextCycle();
        rst                 = 1'b0;
        readModel           = 32'h0;
        ram_en              = 1'b0;
        stall_current_stage = 1'b0;
        bus_addr_ok         = 1'b1;
        bus_data_ok         = 1'b1;
        bus_rdata           = 32'hCAFE_F00D;
        checkIdle(inWait ? "rstWait" : "rstReq");
        nextCycle();
        bus_addr_ok = 1'b0;
        checkIdle(inWait ? "rstWait2" : "rstReq2");
        nextCycle();
        bus_data_ok = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit         isStore;
        logic [3:0] sel;
        rst                 = 1'b1;
        ram_en              = 1'b0;
        ram_write_en        = 1'b0;
        ram_write_sel       = 4'b0000;
        ram_addr            = 32'h0;
        ram_write_data      = 32'h0;
        stall_current_stage = 1'b0;
        bus_addr_ok         = 1'b0;
        bus_data_ok         = 1'b0;
        bus_rdata           = 32'h0;
        nextCycle();
        nextCycle();
        rst = 1'b0;
        checkIdle("reset");
        nextCycle();

        $display("[TB] directed accesses");
        applyStimulus(1'b0, 32'h0000_0100, 32'h0, 4'b0000, 0, 0, 1'b0, 0, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 32'h0000_0204, 32'h1122_3344, 4'b0011, 3, 0, 1'b0, 0, 32'h5555_AAAA);
        applyStimulus(1'b0, 32'h0000_0408, 32'h0, 4'b0000, 1, 2, 1'b1, 2, 32'h0BAD_F00D);
        applyStimulus(1'b1, 32'h0000_050C, 32'h9999_8888, 4'b0000, 0, 0, 1'b0, 0, 32'h0);
        resetDuringAccess(1'b1);
        resetDuringAccess(1'b0);

        $display("[TB] randomized accesses");
        for (int n = 0; n < 60; n++) begin
            isStore = 1'($urandom);
            sel     = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
            applyStimulus(isStore, $urandom, $urandom, sel,
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          1'($urandom), int'($urandom_range(0, 2)), $urandom);
        end
        resetDuringAccess(1'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/mem_bus_bridge.md
MEM_BUS_BRIDGE -- requirements
Module: mem_bus_bridge

Interface
REQ-001 The block SHALL have no parameters; all data and address ports SHALL be `DATA_BUS_WIDTH (32) bits wide.
REQ-002 The block SHALL use one clock, `clk`, and a synchronous active-high reset, `rst`.
REQ-003 Port list, one per line (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ram_en  in  1  MEM-stage access request
- ram_write_en  in  1  1 = store, 0 = load
- ram_write_sel  in  4  store byte enables
- ram_addr  in  32  byte address
- ram_write_data  in  32  store data
- stall_current_stage  in  1  MEM stage held by the pipeline this cycle
- ram_read_data  out  32  load word, raw, unextended
- stall_request  out  1  bridge needs MEM held
- bus_req  out  1  bus request valid
- bus_we  out  1  bus write
- bus_sel  out  4  bus byte enables
- bus_addr  out  32  bus address
- bus_wdata  out  32  bus write data
- bus_addr_ok  in  1  request accepted
- bus_data_ok  in  1  data phase complete
- bus_rdata  in  32  read data

Function
REQ-004 The FSM SHALL have four states: IDLE, REQ, WAIT and HOLD.
REQ-005 IDLE SHALL move to REQ on `ram_en`=1, except for a store with `ram_write_sel`=4'b0000, which SHALL complete locally with no bus traffic and `stall_request`=0.
REQ-006 On the IDLE->REQ transition the block SHALL latch the address, write enable, write data and byte enables; the byte enables latched for a load SHALL be 4'b1111.
REQ-007 While in REQ and WAIT, the `bus_*` outputs SHALL be driven from the latched values and SHALL stay stable regardless of the `ram_*` inputs.
REQ-008 `bus_req` SHALL be 1 only in REQ; REQ SHALL move to WAIT in the cycle `bus_addr_ok`=1.
REQ-009 `bus_data_ok` SHALL be ignored in every state except WAIT.
REQ-010 In WAIT, when `bus_data_ok`=1, the block SHALL capture `bus_rdata` into the read register.
- Next state SHALL be HOLD if `stall_current_stage`=1 in that cycle, else IDLE.
REQ-011 HOLD SHALL return to IDLE in the first cycle `stall_current_stage`=0; no new bus request SHALL be issued while in HOLD.
REQ-012 `stall_request` SHALL equal (IDLE & `ram_en` & not the zero-sel store) | REQ | (WAIT & !`bus_data_ok`); it SHALL be 0 in HOLD.
REQ-013 `ram_read_data` SHALL equal `bus_rdata` in the WAIT cycle with `bus_data_ok`=1, and the read register at all other times.
REQ-014 Minimum latency SHALL be 3 cycles from request to release:
- IDLE detect, then REQ with `bus_addr_ok`, then WAIT with `bus_data_ok`.
- `stall_request` deasserts in the third cycle.
REQ-015 A bus response that arrives after reset or after abandonment SHALL be ignored.

Reset
REQ-016 On `rst`=1 at a clock edge, from any state, the block SHALL enter IDLE.
- The read register and latched request SHALL be cleared to 0.
- `bus_req`=0, `bus_we`=0, `bus_sel`=0, `stall_request`=0 whenever the state is IDLE and `ram_en`=0.
REQ-017 A reset in REQ or WAIT SHALL abandon the access; a later `bus_data_ok` SHALL NOT update `ram_read_data`.

Verification
REQ-018 Load to 0x100, `bus_addr_ok` in the first REQ cycle, `bus_data_ok` with `bus_rdata`=0xDEADBEEF one cycle later -> `bus_sel`=4'b1111, `stall_request`=1,1,0, `ram_read_data`=0xDEADBEEF.
REQ-019 Store of 0x11223344 with sel=4'b0011 to 0x204, `bus_addr_ok` delayed 3 cycles -> `bus_req` high for 4 cycles, `bus_addr`/`bus_wdata`/`bus_sel` stable throughout, `bus_we`=1.
REQ-020 Load completes while `stall_current_stage`=1 for 2 further cycles with `ram_en` still 1 -> HOLD, `bus_req`=0, `ram_read_data` holds the value, IDLE after the stall clears.
REQ-021 Store with sel=4'b0000 -> `stall_request`=0 and `bus_req`=0 throughout.
REQ-022 Reset asserted in WAIT, then `bus_data_ok`=1 with 0xCAFEF00D -> IDLE, `ram_read_data`=0, `stall_request`=0.
